// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, control-bundle types and the ID-stage opcode decoder
// for the five-stage pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_RSVD = 2'b11} aluop_e;
  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10} pc_src_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;
  typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT} dest_sel_e;

  typedef struct packed {
    logic   alusrc;
    aluop_e aluop;
    logic   branch;
    logic   branch_ne;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  typedef struct packed {
    ctrl_t     ctrl;
    dest_sel_e dest_sel;
    logic      use_rs;
    logic      use_rt;
    logic      jump;
    logic      illegal;
  } dec_t;

  // Unknown opcodes leave every control at zero, i.e. they travel as a bubble.
  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_R: begin
        d.ctrl.ex.aluop    = ALU_FUNCT;
        d.ctrl.wb.regwrite = 1'b1;
        d.dest_sel         = DEST_RD;
        d.use_rs           = 1'b1;
        d.use_rt           = 1'b1;
      end
      OP_LW: begin
        d.ctrl.ex.alusrc    = 1'b1;
        d.ctrl.mem.mem_read = 1'b1;
        d.ctrl.wb.memtoreg  = 1'b1;
        d.ctrl.wb.regwrite  = 1'b1;
        d.dest_sel          = DEST_RT;
        d.use_rs            = 1'b1;
      end
      OP_SW: begin
        d.ctrl.ex.alusrc     = 1'b1;
        d.ctrl.mem.mem_write = 1'b1;
        d.use_rs             = 1'b1;
        d.use_rt             = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.ctrl.ex.branch    = (op == OP_BEQ);
        d.ctrl.ex.branch_ne = (op == OP_BNE);
        d.ctrl.ex.aluop     = ALU_SUB;
        d.use_rs            = 1'b1;
        d.use_rt            = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.ex.alusrc   = 1'b1;
        d.ctrl.wb.regwrite = 1'b1;
        d.dest_sel         = DEST_RT;
        d.use_rs           = 1'b1;
      end
      OP_J:    d.jump    = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_hazard.sv
// Combinational hazard unit: RAW stall detection, EX operand forwarding and
// the branch > stall > jump redirect priority.
module hazard_forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_jump,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_mem_read,
  input  logic                  ex_regwrite,
  input  logic                  ex_branch,
  input  logic                  ex_branch_ne,
  input  logic                  ex_zero,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_regwrite,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [1:0]            pc_src,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  idex_bubble,
  output logic                  stall,
  output logic                  flush
);

  logic ex_hit, mem_hit, hazard, branch_taken, jump_taken;

  function automatic fwd_e fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                   input logic m_rw, input logic [REG_ADDR_W-1:0] m_dest,
                                   input logic w_rw, input logic [REG_ADDR_W-1:0] w_dest);
    if (m_rw && m_dest != '0 && m_dest == src) return FWD_MEM;
    if (w_rw && w_dest != '0 && w_dest == src) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    ex_hit  = (ex_dest != '0) &&
              ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
    mem_hit = (mem_dest != '0) &&
              ((id_use_rs && id_rs == mem_dest) || (id_use_rt && id_rt == mem_dest));
    // Without forwarding every producer still in EX or MEM blocks the consumer.
    if (ENABLE_FWD) hazard = ex_mem_read && ex_hit;
    else            hazard = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);

    branch_taken = (ex_branch && ex_zero) || (ex_branch_ne && !ex_zero);
    stall        = hazard && !branch_taken;
    jump_taken   = id_jump && !branch_taken && !stall;

    pc_write    = !stall;
    ifid_write  = !stall;
    ifid_flush  = branch_taken || jump_taken;
    flush       = ifid_flush;
    idex_bubble = branch_taken || stall;
    pc_src      = branch_taken ? PC_BRANCH : (jump_taken ? PC_JUMP : PC_SEQ);

    fwd_a = ENABLE_FWD ? fwd_sel(ex_rs, mem_regwrite, mem_dest, wb_regwrite, wb_dest) : FWD_RF;
    fwd_b = ENABLE_FWD ? fwd_sel(ex_rt, mem_regwrite, mem_dest, wb_regwrite, wb_dest) : FWD_RF;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, sticky illegal-opcode flag and saturating event counters.
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter bit ENABLE_FWD = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [1:0]            pc_src,
  output logic                  ex_alusrc,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
  } idex_t;

  typedef struct packed {
    mem_ctrl_t             mem;
    wb_ctrl_t              wb;
    logic [REG_ADDR_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t              wb;
    logic [REG_ADDR_W-1:0] dest;
  } memwb_t;

  dec_t                  dec;
  logic [REG_ADDR_W-1:0] id_dest;
  idex_t                 idex_d, idex_q;
  exmem_t                exmem_d, exmem_q;
  memwb_t                memwb_d, memwb_q;
  logic                  illegal_d, illegal_q;
  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic                  idex_bubble, stall, flush;

  hazard_forward_unit #(.REG_ADDR_W(REG_ADDR_W), .ENABLE_FWD(ENABLE_FWD)) u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (dec.use_rs),
    .id_use_rt    (dec.use_rt),
    .id_jump      (dec.jump),
    .ex_rs        (idex_q.rs),
    .ex_rt        (idex_q.rt),
    .ex_dest      (idex_q.dest),
    .ex_mem_read  (idex_q.ctrl.mem.mem_read),
    .ex_regwrite  (idex_q.ctrl.wb.regwrite),
    .ex_branch    (idex_q.ctrl.ex.branch),
    .ex_branch_ne (idex_q.ctrl.ex.branch_ne),
    .ex_zero      (ex_zero),
    .mem_dest     (exmem_q.dest),
    .mem_regwrite (exmem_q.wb.regwrite),
    .wb_dest      (memwb_q.dest),
    .wb_regwrite  (memwb_q.wb.regwrite),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .pc_src       (pc_src),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .idex_bubble  (idex_bubble),
    .stall        (stall),
    .flush        (flush)
  );

  always_comb begin
    dec = decode(id_opcode);
    case (dec.dest_sel)
      DEST_RD: id_dest = id_rd;
      DEST_RT: id_dest = id_rt;
      default: id_dest = '0;
    endcase

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    idex_d = '0;
    if (!idex_bubble) begin
      idex_d.ctrl = dec.ctrl;
      // Only fields the instruction actually reads are carried, so unused ones never forward.
      idex_d.rs   = dec.use_rs ? id_rs : '0;
      idex_d.rt   = dec.use_rt ? id_rt : '0;
      idex_d.dest = id_dest;
    end

    exmem_d.mem  = idex_q.ctrl.mem;
    exmem_d.wb   = idex_q.ctrl.wb;
    exmem_d.dest = idex_q.dest;
    memwb_d.wb   = exmem_q.wb;
    memwb_d.dest = exmem_q.dest;

    illegal_d   = illegal_q || dec.illegal;
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_alusrc    = idex_q.ctrl.ex.alusrc;
  assign ex_aluop     = ALUOP_W'(idex_q.ctrl.ex.aluop);
  assign ex_dest      = idex_q.dest;
  assign mem_read     = exmem_q.mem.mem_read;
  assign mem_write    = exmem_q.mem.mem_write;
  assign wb_regwrite  = memwb_q.wb.regwrite;
  assign wb_memtoreg  = memwb_q.wb.memtoreg;
  assign wb_dest      = memwb_q.dest;
  assign illegal_op   = illegal_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios on a forwarding and a
// non-forwarding instance, then random programs against an instruction-level model.
module tb_pipeline_control_unit;

  localparam int RW    = 5;
  localparam int CW    = 4;
  localparam int OBS_W = 35;

  localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04,
                         T_BNE = 6'h05, T_ADDI = 6'h08, T_J = 6'h02;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [5:0]    id_opcode = T_R;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          ex_zero = 1'b0;

  // Index 0: forwarding instance, index 1: stall-only instance.
  logic          pc_write [2], ifid_write [2], ifid_flush [2], ex_alusrc [2];
  logic [1:0]    pc_src [2], ex_aluop [2], fwd_a [2], fwd_b [2];
  logic [RW-1:0] ex_dest [2], wb_dest [2];
  logic          mem_read [2], mem_write [2], wb_regwrite [2], wb_memtoreg [2], illegal_op [2];
  logic [CW-1:0] stall_cycles [2], flush_events [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipeline_control_unit #(.REG_ADDR_W(RW), .ALUOP_W(2), .ENABLE_FWD(g == 0), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .ex_zero(ex_zero), .pc_write(pc_write[g]), .ifid_write(ifid_write[g]),
      .ifid_flush(ifid_flush[g]), .pc_src(pc_src[g]), .ex_alusrc(ex_alusrc[g]),
      .ex_aluop(ex_aluop[g]), .ex_dest(ex_dest[g]), .fwd_a(fwd_a[g]), .fwd_b(fwd_b[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .wb_regwrite(wb_regwrite[g]),
      .wb_memtoreg(wb_memtoreg[g]), .wb_dest(wb_dest[g]), .illegal_op(illegal_op[g]),
      .stall_cycles(stall_cycles[g]), .flush_events(flush_events[g])
    );
  end

  // ---------------- instruction-level reference model ----------------
  typedef struct packed {
    logic          bub;
    logic [5:0]    op;
    logic [RW-1:0] rs, rt, rd;
  } instr_t;

  localparam instr_t BUBBLE = '{bub: 1'b1, op: 6'h00, rs: '0, rt: '0, rd: '0};
  localparam instr_t NOP    = '{bub: 1'b0, op: 6'h00, rs: '0, rt: '0, rd: '0};

  function automatic bit legal(input logic [5:0] op);
    return op inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J};
  endfunction
  function automatic bit writes_reg(input instr_t i);
    return !i.bub && (i.op inside {T_R, T_LW, T_ADDI});
  endfunction
  function automatic logic [RW-1:0] dest_of(input instr_t i);
    if (i.bub) return '0;
    if (i.op == T_R) return i.rd;
    if (i.op inside {T_LW, T_ADDI}) return i.rt;
    return '0;
  endfunction
  function automatic bit reads_rs(input instr_t i);
    return !i.bub && legal(i.op) && i.op != T_J;
  endfunction
  function automatic bit reads_rt(input instr_t i);
    return !i.bub && (i.op inside {T_R, T_SW, T_BEQ, T_BNE});
  endfunction
  function automatic bit depends(input instr_t id, input logic [RW-1:0] d);
    return d != '0 && ((reads_rs(id) && id.rs == d) || (reads_rt(id) && id.rt == d));
  endfunction
  function automatic logic [1:0] fwd_pick(input logic [RW-1:0] src, input instr_t m, input instr_t w);
    if (writes_reg(m) && dest_of(m) != '0 && dest_of(m) == src) return 2'b10;
    if (writes_reg(w) && dest_of(w) != '0 && dest_of(w) == src) return 2'b01;
    return 2'b00;
  endfunction
  function automatic instr_t rand_instr();
    instr_t i;
    i.bub = 1'b0;
    i.rs  = RW'($urandom_range(0, 3));
    i.rt  = RW'($urandom_range(0, 3));
    i.rd  = RW'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0, 1:    i.op = T_R;
      2, 3:    i.op = T_LW;
      4:       i.op = T_SW;
      5:       i.op = T_BEQ;
      6:       i.op = T_BNE;
      7, 8:    i.op = T_ADDI;
      9:       i.op = T_J;
      default: i.op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
    endcase
    return i;
  endfunction

  function automatic logic [OBS_W-1:0] obs(input int m);
    return {pc_write[m], ifid_write[m], ifid_flush[m], pc_src[m], ex_alusrc[m], ex_aluop[m],
            ex_dest[m], fwd_a[m], fwd_b[m], mem_read[m], mem_write[m], wb_regwrite[m],
            wb_memtoreg[m], wb_dest[m], illegal_op[m], stall_cycles[m], flush_events[m]};
  endfunction

  localparam logic [OBS_W-1:0] RESET_OBS = {2'b11, 33'b0};

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [5:0] op, input logic [RW-1:0] rs, rt, rd);
    id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    put(T_R, 0, 0, 0);
    ex_zero = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    put(T_R, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== RESET_OBS) begin
        bad++; $display("FAIL reset_outputs dut%0d got=%h want=%h", m, obs(m), RESET_OBS);
      end
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    do_reset();
    put(T_R, 1, 2, 3); tick();
    put(T_R, 0, 0, 0); @(negedge clk);
    total++; if ({ex_aluop[0], ex_dest[0], ex_alusrc[0]} !== {2'b10, 5'd3, 1'b0}) begin
      bad++; $display("FAIL rtype_ex got=%b/%0d want=10/3", ex_aluop[0], ex_dest[0]); end
    tick(); tick(); @(negedge clk);
    total++; if ({wb_regwrite[0], wb_dest[0], wb_memtoreg[0]} !== {1'b1, 5'd3, 1'b0}) begin
      bad++; $display("FAIL rtype_wb got=%b/%0d/%b want=1/3/0", wb_regwrite[0], wb_dest[0], wb_memtoreg[0]); end
  endtask

  task automatic test_load_use();
    do_reset();
    put(T_LW, 1, 2, 0); tick();
    put(T_R, 2, 4, 6); @(negedge clk);
    total++; if ({pc_write[0], ifid_write[0]} !== 2'b00) begin
      bad++; $display("FAIL loaduse_hold got=%b want=00", {pc_write[0], ifid_write[0]}); end
    tick(); @(negedge clk);
    total++; if ({ex_aluop[0], ex_dest[0], stall_cycles[0], pc_write[0]} !== {2'b00, 5'd0, 4'd1, 1'b1}) begin
      bad++; $display("FAIL loaduse_bubble got aluop=%b dest=%0d stalls=%0d pcw=%b want 0/0/1/1",
                      ex_aluop[0], ex_dest[0], stall_cycles[0], pc_write[0]); end
    tick(); @(negedge clk);
    total++; if ({fwd_a[0], fwd_b[0], ex_dest[0]} !== {2'b01, 2'b00, 5'd6}) begin
      bad++; $display("FAIL loaduse_fwd got fa=%b fb=%b dest=%0d want 01/00/6", fwd_a[0], fwd_b[0], ex_dest[0]); end
  endtask

  task automatic test_forward_mem();
    do_reset();
    put(T_ADDI, 0, 5, 0); tick();
    put(T_SW, 1, 5, 0); @(negedge clk);
    total++; if (pc_write[0] !== 1'b1) begin
      bad++; $display("FAIL addi_sw_nostall got=%b want=1", pc_write[0]); end
    tick(); put(T_R, 0, 0, 0); @(negedge clk);
    total++; if ({fwd_b[0], fwd_a[0], ex_alusrc[0], stall_cycles[0]} !== {2'b10, 2'b00, 1'b1, 4'd0}) begin
      bad++; $display("FAIL addi_sw_fwd got fb=%b fa=%b alusrc=%b stalls=%0d want 10/00/1/0",
                      fwd_b[0], fwd_a[0], ex_alusrc[0], stall_cycles[0]); end
  endtask

  task automatic test_branch();
    do_reset();
    put(T_BEQ, 1, 2, 0); tick();
    put(T_R, 1, 2, 3); ex_zero = 1'b1; @(negedge clk);
    total++; if ({pc_src[0], ifid_flush[0]} !== 3'b011) begin
      bad++; $display("FAIL beq_taken got pc_src=%b flush=%b want 01/1", pc_src[0], ifid_flush[0]); end
    tick(); put(T_R, 0, 0, 0); ex_zero = 1'b0; @(negedge clk);
    total++; if ({ex_aluop[0], ex_dest[0], flush_events[0]} !== {2'b00, 5'd0, 4'd1}) begin
      bad++; $display("FAIL beq_squash got aluop=%b dest=%0d flushes=%0d want 0/0/1",
                      ex_aluop[0], ex_dest[0], flush_events[0]); end
    put(T_BEQ, 1, 2, 0); tick();
    put(T_R, 1, 2, 3); ex_zero = 1'b0; @(negedge clk);
    total++; if ({pc_src[0], ifid_flush[0]} !== 3'b000) begin
      bad++; $display("FAIL beq_not_taken got pc_src=%b flush=%b want 00/0", pc_src[0], ifid_flush[0]); end
    tick(); @(negedge clk);
    total++; if ({ex_aluop[0], ex_dest[0], flush_events[0]} !== {2'b10, 5'd3, 4'd1}) begin
      bad++; $display("FAIL beq_fallthru got aluop=%b dest=%0d flushes=%0d want 10/3/1",
                      ex_aluop[0], ex_dest[0], flush_events[0]); end
  endtask

  // Stall-only instance: ADDI r4 sits in MEM while BNE is in EX and an r4 reader is in ID.
  task automatic test_bne_over_stall();
    do_reset();
    put(T_ADDI, 0, 4, 0); tick();
    put(T_BNE, 1, 2, 0); tick();
    put(T_R, 4, 0, 7); ex_zero = 1'b0; @(negedge clk);
    total++; if ({pc_write[1], pc_src[1], ifid_flush[1]} !== 4'b1011) begin
      bad++; $display("FAIL bne_over_stall got pcw=%b pc_src=%b flush=%b want 1/01/1",
                      pc_write[1], pc_src[1], ifid_flush[1]); end
    tick(); put(T_R, 0, 0, 0); @(negedge clk);
    total++; if ({stall_cycles[1], flush_events[1]} !== {4'd0, 4'd1}) begin
      bad++; $display("FAIL bne_counters got stalls=%0d flushes=%0d want 0/1", stall_cycles[1], flush_events[1]); end
  endtask

  task automatic test_illegal_and_midstall_reset();
    do_reset();
    put(6'h3F, 1, 2, 3); @(negedge clk);
    total++; if (illegal_op[0] !== 1'b0) begin
      bad++; $display("FAIL illegal_early got=%b want=0", illegal_op[0]); end
    tick(); put(T_R, 1, 2, 4); @(negedge clk);
    total++; if ({illegal_op[0], ex_aluop[0], ex_dest[0]} !== {1'b1, 2'b00, 5'd0}) begin
      bad++; $display("FAIL illegal_set got ill=%b aluop=%b dest=%0d want 1/0/0", illegal_op[0], ex_aluop[0], ex_dest[0]); end
    tick(); put(T_LW, 0, 2, 0); tick();
    put(T_R, 2, 1, 5); @(negedge clk);
    total++; if ({pc_write[0], pc_write[1]} !== 2'b00) begin
      bad++; $display("FAIL midstall_enter got=%b want=00", {pc_write[0], pc_write[1]}); end
    tick(); @(negedge clk);
    total++; if ({pc_write[1], stall_cycles[1], illegal_op[1]} !== {1'b0, 4'd1, 1'b1}) begin
      bad++; $display("FAIL midstall_second got pcw=%b stalls=%0d ill=%b want 0/1/1",
                      pc_write[1], stall_cycles[1], illegal_op[1]); end
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs(m) !== RESET_OBS) begin
        bad++; $display("FAIL midstall_reset dut%0d got=%h want=%h", m, obs(m), RESET_OBS);
      end
    end
    tick();
    rst_n = 1'b1;
  endtask

  // Random program; the bench plays the datapath (holds ID on stall, zeroes it on flush).
  task automatic test_random(input int m, input int n);
    instr_t id, ex, mem, wb;
    bit ill, taken, hz, stall, jmp;
    logic [CW-1:0] stalls, flushes;
    logic [1:0] pcs, alu;
    logic [OBS_W-1:0] want;
    do_reset();
    id = NOP; ex = BUBBLE; mem = BUBBLE; wb = BUBBLE;
    ill = 1'b0; stalls = '0; flushes = '0;
    for (int c = 0; c < n; c++) begin
      put(id.op, id.rs, id.rt, id.rd);
      ex_zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      taken = !ex.bub && ((ex.op == T_BEQ && ex_zero) || (ex.op == T_BNE && !ex_zero));
      if (m == 0) hz = !ex.bub && ex.op == T_LW && depends(id, dest_of(ex));
      else        hz = (writes_reg(ex) && depends(id, dest_of(ex))) || (writes_reg(mem) && depends(id, dest_of(mem)));
      stall = hz && !taken;
      jmp   = !id.bub && id.op == T_J && !taken && !stall;
      pcs   = taken ? 2'b01 : (jmp ? 2'b10 : 2'b00);
      alu   = ex.bub ? 2'b00 : (ex.op == T_R ? 2'b10 : ((ex.op inside {T_BEQ, T_BNE}) ? 2'b01 : 2'b00));
      want  = {!stall, !stall, taken || jmp, pcs, !ex.bub && (ex.op inside {T_LW, T_SW, T_ADDI}), alu,
               dest_of(ex),
               (m == 0) ? fwd_pick(reads_rs(ex) ? ex.rs : '0, mem, wb) : 2'b00,
               (m == 0) ? fwd_pick(reads_rt(ex) ? ex.rt : '0, mem, wb) : 2'b00,
               !mem.bub && mem.op == T_LW, !mem.bub && mem.op == T_SW,
               writes_reg(wb), !wb.bub && wb.op == T_LW, dest_of(wb), ill, stalls, flushes};
      total++;
      if (obs(m) !== want) begin
        bad++; $display("FAIL random dut%0d cycle %0d got=%h want=%h", m, c, obs(m), want);
      end
      wb  = mem;
      mem = ex;
      ex  = (taken || stall) ? BUBBLE : id;
      if (!legal(id.op)) ill = 1'b1;
      if (stall && stalls != '1) stalls = stalls + 1'b1;
      if ((taken || jmp) && flushes != '1) flushes = flushes + 1'b1;
      if (!stall) id = (taken || jmp) ? NOP : rand_instr();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_forward_mem();
    test_branch();
    test_bne_over_stall();
    test_illegal_and_midstall_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Second-generation control unit for the 5-stage MIPS pipeline. Decodes the ID-stage opcode, adds ADDI, BNE and J to the existing R/LW/SW/BEQ set, and carries control bundles through the ID/EX, EX/MEM and MEM/WB registers. Also owns load-use hazard detection, forwarding selection, branch/jump flush, sticky illegal-opcode detection and saturating performance counters. Sits beside the datapath and drives its stage muxes and pipeline-register enables.

Parameters:
REG_ADDR_W, 5, register-index width
ALUOP_W, 2, ALUOp width (00 add, 01 sub, 10 funct-decoded, 11 reserved)
ENABLE_FWD, 1, 1 = forwarding with load-use stall only; 0 = no forwarding, stall on every RAW hazard against EX/MEM
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_opcode  in  6  opcode of instruction in ID
id_rs  in  REG_ADDR_W  rs field in ID
id_rt  in  REG_ADDR_W  rt field in ID
id_rd  in  REG_ADDR_W  rd field in ID
ex_zero  in  1  ALU zero flag for instruction in EX
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero IF/ID on next edge
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
ex_alusrc  out  1  EX ALU B-operand select immediate
ex_aluop  out  ALUOP_W  EX ALU operation class
ex_dest  out  REG_ADDR_W  destination register in EX
fwd_a  out  2  ALU A select: 00 regfile, 01 WB, 10 MEM
fwd_b  out  2  ALU B select, same encoding
mem_read  out  1  MEM data-memory read
mem_write  out  1  MEM data-memory write
wb_regwrite  out  1  WB register write
wb_memtoreg  out  1  WB result select memory
wb_dest  out  REG_ADDR_W  WB destination register
illegal_op  out  1  sticky unknown-opcode flag
stall_cycles  out  CNT_W  saturating count of stall cycles
flush_events  out  CNT_W  saturating count of branch/jump flushes

Behaviour:
- Decode (comb, ID): R 000000 (RegDst=rd, ALUOp 10, RegWrite); LW 100011 (ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp 00); SW 101011 (ALUSrc, MemWrite); BEQ 000100 / BNE 000101 (Branch / BranchNe, ALUOp 01); ADDI 001000 (ALUSrc, RegWrite, dest=rt, ALUOp 00); J 000010 (Jump). Any other opcode decodes to a bubble and sets illegal_op on the next edge; it stays set until reset.
- Dest = rd for R-type, rt for LW/ADDI, 0 otherwise. Source use: rs by all except J; rt by R, SW, BEQ, BNE.
- Pipeline: ID bundle -> ID/EX -> EX/MEM -> MEM/WB. The stage registers also hold rs, rt, dest, Branch, BranchNe, MemRead and RegWrite. Each stage advances every cycle; only IF/ID and PC are held during a stall.
- Branch taken (EX) = (Branch & ex_zero) | (BranchNe & ~ex_zero). Then pc_src=01, ifid_flush=1, and the ID/EX load is a bubble (two younger instructions squashed). flush_events increments.
- Jump (ID, not overridden): pc_src=10, ifid_flush=1, the J bubble enters ID/EX, and flush_events increments.
- Load-use stall (ENABLE_FWD=1): EX MemRead & ex_dest!=0 & ex_dest matches a used ID source. Response: pc_write=0, ifid_write=0, bubble into ID/EX. Exactly 1 cycle.
- ENABLE_FWD=0: stall while a used ID source equals a nonzero dest with RegWrite in EX or MEM. Lasts up to 2 cycles. fwd_a/fwd_b are held 00. The register file is write-before-read, so WB needs no check.
- Forwarding: fwd_a=10 if MEM RegWrite & mem_dest!=0 & mem_dest==ex_rs; else 01 if the same condition holds for WB; else 00. fwd_b is the same against ex_rt. MEM has priority.
- Priority: branch-taken > stall > jump. A taken branch cancels a coincident stall (pc_write=1) and the ID jump.
- stall_cycles increments on each stall cycle. Both counters saturate at all-ones.
- Reset (async, any time incl. mid-stall): all stage registers become bubbles (all controls 0, dests 0). pc_write=1, ifid_write=1, ifid_flush=0, pc_src=00, fwd=00, illegal_op=0, counters=0.

Decomposition:
- Shared package pipe_ctrl_pkg holds: opcode constants, ALUOp and pc_src/fwd encodings, and the control-bundle struct typedef (ex/mem/wb fields).
- One sub-module, hazard_forward_unit, is combinational: stall, forwarding and flush priority.
- Decode and stage registers stay in the top module.

Test Plan:
- Reset then R-type add (rd=3) -> at EX: ex_aluop=10, ex_dest=3; 2 cycles later: wb_regwrite=1, wb_dest=3, wb_memtoreg=0.
- LW r2 then ADD using r2 (ENABLE_FWD=1) -> one cycle pc_write=0/ifid_write=0, EX bubble, stall_cycles=1; fwd_a=01 when ADD reaches EX.
- ADDI r5 then SW with rt=r5 -> no stall; fwd_b=10 in EX.
- BEQ with ex_zero=1 -> pc_src=01, ifid_flush=1, next EX is bubble, flush_events=1; same with ex_zero=0 -> no flush.
- BNE taken while a load-use stall is pending -> branch wins, pc_write=1, stall_cycles unchanged.
- Opcode 111111 -> illegal_op=1 and stays 1 through later legal ops; assert rst_n=0 mid-stall -> all outputs reach reset values immediately.
